// File: rtl/ext_arbiter.sv
// ext_arbiter: round-robin share of one immediate-extension unit between two requesters, one-entry registered result.
// Optional grant statistics counters enabled by defining EXT_STATS_EN.
module ext_arbiter #(
  parameter int TAG_W = 4
`ifdef EXT_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [15:0]      req_imm0,
  input  logic [1:0]       req_eop0,
  input  logic [TAG_W-1:0] req_tag0,
  input  logic [15:0]      req_imm1,
  input  logic [1:0]       req_eop1,
  input  logic [TAG_W-1:0] req_tag1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_ext,
  output logic             out_src,
  output logic [TAG_W-1:0] out_tag
`ifdef EXT_STATS_EN
  , output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0]   grant_cnt1
`endif
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t            r_state, w_next;
  logic              r_ptr;
  logic              w_accept, w_pick1, w_take;
  logic [15:0]       w_imm;
  logic [1:0]        w_eop;
  logic [TAG_W-1:0]  w_tag;
  logic [31:0]       w_ext;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  // r_ptr=1 hands priority to requester 1 when both are valid
  always_comb begin
    w_accept  = (r_state == IDLE) | out_ready;
    w_pick1   = req_valid[1] & (~req_valid[0] | r_ptr);
    req_ready = {w_pick1, req_valid[0] & ~w_pick1} & {2{w_accept}};
    w_take    = |req_ready;
    w_next    = w_take ? HOLD : (out_ready ? IDLE : r_state);
    w_imm     = w_pick1 ? req_imm1 : req_imm0;
    w_eop     = w_pick1 ? req_eop1 : req_eop0;
    w_tag     = w_pick1 ? req_tag1 : req_tag0;
    w_ext     = w_eop == 2'd0 ? {{16{w_imm[15]}}, w_imm} :
                w_eop == 2'd1 ? {16'h0, w_imm} :
                w_eop == 2'd2 ? {w_imm, 16'h0} :
                                {{14{w_imm[15]}}, w_imm, 2'b00};
  end
  assign out_valid = (r_state == HOLD);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      out_ext <= '0;
      out_src <= 1'b0;
      out_tag <= '0;
      r_ptr   <= 1'b0;
    end else if (w_take) begin
      out_ext <= w_ext;
      out_src <= w_pick1;
      out_tag <= w_tag;
      r_ptr   <= ~w_pick1;
    end
`ifdef EXT_STATS_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req_ready[0] && !(&grant_cnt0)) grant_cnt0 <= grant_cnt0 + 1'b1;
      if (req_ready[1] && !(&grant_cnt1)) grant_cnt1 <= grant_cnt1 + 1'b1;
    end
`endif
endmodule

// File: tb/tb_ext_arbiter.sv
// tb_ext_arbiter: randomized + directed scoreboard bench for ext_arbiter against a behavioural model.
module tb_ext_arbiter;
  localparam int CNT_W = 2;
  logic        clk = 0, reset = 1;
  logic [1:0]  req_valid = 0, req_ready;
  logic [15:0] req_imm0 = 0, req_imm1 = 0;
  logic [1:0]  req_eop0 = 0, req_eop1 = 0;
  logic [3:0]  req_tag0 = 0, req_tag1 = 0, out_tag;
  logic        out_valid, out_ready = 0, out_src;
  logic [31:0] out_ext;
`ifdef EXT_STATS_EN
  logic [CNT_W-1:0] grant_cnt0, grant_cnt1;
`endif
  ext_arbiter #(
    .TAG_W(4)
`ifdef EXT_STATS_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_imm0(req_imm0), .req_eop0(req_eop0), .req_tag0(req_tag0),
    .req_imm1(req_imm1), .req_eop1(req_eop1), .req_tag1(req_tag1),
    .out_valid(out_valid), .out_ready(out_ready), .out_ext(out_ext),
    .out_src(out_src), .out_tag(out_tag)
`ifdef EXT_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {logic src; logic [3:0] tag; logic [31:0] ext;} exp_t;
  exp_t q[$];
  int chk = 0, err = 0;
  int busy = 0, ptr = 0;
  int mcnt[2] = '{0, 0};
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] eop);
    int s;
    s = $signed(imm);
    case (eop)
      2'd0: return s;
      2'd1: return 32'(imm);
      2'd2: return 32'(imm) * 32'h10000;
      default: return s * 4;
    endcase
  endfunction
  // model of one cycle, evaluated at the negedge after inputs settle
  task automatic step();
    int win;
    logic [1:0] exp_rdy;
    exp_t e;
    win = -1;
    if (busy == 0 || out_ready) begin
      if (req_valid == 2'b11) win = ptr;
      else if (req_valid == 2'b01) win = 0;
      else if (req_valid == 2'b10) win = 1;
    end
    exp_rdy = (win < 0) ? 2'b00 : 2'(1 << win);
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("out_valid", 32'(out_valid), busy);
`ifdef EXT_STATS_EN
    check("grant_cnt0", 32'(grant_cnt0), mcnt[0]);
    check("grant_cnt1", 32'(grant_cnt1), mcnt[1]);
`endif
    if (win >= 0) begin
      e.src = 1'(win);
      e.tag = win ? req_tag1 : req_tag0;
      e.ext = win ? ref_ext(req_imm1, req_eop1) : ref_ext(req_imm0, req_eop0);
      q.push_back(e);
      ptr = 1 - win;
      busy = 1;
      if (mcnt[win] < (1 << CNT_W) - 1) mcnt[win]++;
    end else if (busy != 0 && out_ready) busy = 0;
  endtask
  always @(negedge clk)
    if (reset && out_valid) begin
      if (q.size() == 0) begin
        chk++; err++;
        $display("FAIL out_unexpected: got valid result %h expected none", out_ext);
      end else begin
        check("out_src", 32'(out_src), 32'(q[0].src));
        check("out_tag", 32'(out_tag), 32'(q[0].tag));
        check("out_ext", out_ext, q[0].ext);
        if (out_ready) void'(q.pop_front());
      end
    end
  task automatic drive(input logic [1:0] v, input logic [15:0] i0, input logic [1:0] e0, input logic [3:0] t0,
                       input logic [15:0] i1, input logic [1:0] e1, input logic [3:0] t1, input logic ordy);
    @(posedge clk); #1;
    req_valid = v; req_imm0 = i0; req_eop0 = e0; req_tag0 = t0;
    req_imm1 = i1; req_eop1 = e1; req_tag1 = t1; out_ready = ordy;
    @(negedge clk);
    step();
  endtask
  task automatic do_reset();
    @(posedge clk); #1;
    reset = 0; req_valid = 0;
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_ext", out_ext, 0);
    check("rst_out_src_tag", {27'(out_src), out_tag}, 0);
    q.delete(); busy = 0; ptr = 0; mcnt = '{0, 0};
    @(negedge clk); #1;
    reset = 1;
  endtask
  initial begin
    #1 reset = 0;
    #2;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_ext", out_ext, 0);
    check("rst_out_src_tag", {27'(out_src), out_tag}, 0);
    @(negedge clk); #1 reset = 1;
    for (int e = 0; e < 4; e++) drive(2'b01, 16'h8006, 2'(e), 4'(e), 16'h0, 2'd0, 4'h0, 1'b1);
    drive(2'b00, 0, 0, 0, 0, 0, 0, 1'b1);
    drive(2'b01, 16'h7FFF, 2'd0, 4'h5, 0, 0, 0, 1'b1);
    drive(2'b10, 0, 0, 0, 16'h7FFF, 2'd3, 4'h6, 1'b1);
    drive(2'b00, 0, 0, 0, 0, 0, 0, 1'b1);
    for (int i = 0; i < 6; i++) drive(2'b11, 16'(i), 2'd1, 4'(i), 16'(100 + i), 2'd1, 4'(8 + i), 1'b1);
    drive(2'b00, 0, 0, 0, 0, 0, 0, 1'b1);
    drive(2'b01, 16'h1234, 2'd2, 4'h3, 0, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) drive(2'b10, 0, 0, 0, 16'hABCD, 2'd0, 4'h9, 1'b0);
    drive(2'b10, 0, 0, 0, 16'hABCD, 2'd0, 4'h9, 1'b1);
    drive(2'b01, 16'h4321, 2'd3, 4'h1, 0, 0, 0, 1'b0);
    do_reset();
    drive(2'b11, 16'h0011, 2'd0, 4'hA, 16'h0022, 2'd0, 4'hB, 1'b1);
    drive(2'b00, 0, 0, 0, 0, 0, 0, 1'b1);
    for (int i = 0; i < 300; i++)
      drive(2'($urandom), 16'($urandom), 2'($urandom), 4'($urandom),
            16'($urandom), 2'($urandom), 4'($urandom), $urandom_range(0, 3) != 0);
    drive(2'b00, 0, 0, 0, 0, 0, 0, 1'b1);
`ifdef EXT_STATS_EN
    do_reset();
    for (int i = 0; i < 5; i++) drive(2'b01, 16'(i), 2'd0, 4'(i), 0, 0, 0, 1'b1);
    drive(2'b00, 0, 0, 0, 0, 0, 0, 1'b1);
    check("sat_cnt0", 32'(grant_cnt0), 3);
    check("sat_cnt1", 32'(grant_cnt1), 0);
`endif
    drive(2'b00, 0, 0, 0, 0, 0, 0, 1'b1);
    check("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end
endmodule
